// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared encodings for the byte-wide memory bus initiator
package mem_master_pkg;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [15:0] IO_OUT_BASE = 16'hfff8;
   localparam logic [15:0] IO_IN_BASE = 16'hfffc;
   typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      return sz == SZ_BYTE ? 3'd1 : sz == SZ_HALF ? 3'd2 : 3'd4;
   endfunction
   function automatic logic [31:0] lane_mask(input logic [2:0] n);
      return n == 3'd1 ? 32'h0000_00ff : n == 3'd2 ? 32'h0000_ffff : 32'hffff_ffff;
   endfunction
endpackage

// File: rtl/mem_master.sv
// mem_master: splits 1/2/4-byte CPU requests into little-endian single-byte memory accesses
module mem_master
   import mem_master_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [15:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata
);
   state_t state;
   logic [2:0] n;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic [1:0] i, w;
   logic [1:0] i_nx;
   logic [15:0] addr_nx;
   logic last;
   assign i_nx = i + 2'd1;
   assign addr_nx = addr + {14'd0, i_nx};
   assign last = {1'b0, i} == n - 3'd1;
   assign req_ready = state == IDLE && !reset;
   // transfer sequencer: one cycle per written byte, RD_LAT cycles per read byte
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         n <= 3'd0;
         addr <= 16'd0;
         wdata <= 32'd0;
         i <= 2'd0;
         w <= 2'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         mem_addr <= 16'd0;
         mem_wdata <= 8'd0;
         mem_we <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               n <= size_bytes(req_size);
               addr <= req_addr;
               wdata <= req_wdata;
               i <= 2'd0;
               w <= 2'd0;
               mem_addr <= req_addr;
               mem_wdata <= req_wdata[7:0];
               mem_we <= req_write;
               state <= req_write ? WR : RD;
               if (!req_write) resp_rdata <= resp_rdata & lane_mask(size_bytes(req_size));
            end
            WR: if (last) begin
               state <= DONE;
               mem_we <= 1'b0;
               resp_valid <= 1'b1;
            end else begin
               i <= i_nx;
               mem_addr <= addr_nx;
               mem_wdata <= wdata[{i_nx, 3'b000} +: 8];
            end
            RD: if (w == 2'(RD_LAT - 1)) begin
               resp_rdata[{i, 3'b000} +: 8] <= mem_rdata;
               w <= 2'd0;
               if (last) begin
                  state <= DONE;
                  resp_valid <= 1'b1;
               end else begin
                  i <= i_nx;
                  mem_addr <= addr_nx;
               end
            end else w <= w + 2'd1;
            default: begin
               resp_valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: vector table, corner sequences and randomized traffic against a byte-array model
module tb_mem_master;
   localparam int RD_LAT = 2;
   logic clk, reset, req_valid, req_ready, req_write, resp_valid, mem_we;
   logic [1:0] req_size;
   logic [15:0] req_addr, mem_addr;
   logic [31:0] req_wdata, resp_rdata;
   logic [7:0] mem_wdata, mem_rdata;
   logic [7:0] mem [65536];
   logic [7:0] ref_mem [65536];
   int pass_cnt = 0, total_cnt = 0;

   mem_master #(.RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   typedef struct {
      bit wr;
      logic [1:0] sz;
      logic [15:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      int exp_lat;
   } vec_t;
   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else pass_cnt++;
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_read(input logic [15:0] a, input int nb);
      logic [31:0] v = 0;
      for (int j = 0; j < nb; j++) v = v | (32'(ref_mem[a + 16'(j)]) << (8 * j));
      return v;
   endfunction

   // starts and ends at a negedge with the DUT idle
   task automatic xfer(input string tag, input bit wr, input logic [1:0] sz, input logic [15:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lat);
      int nb, idx, bad, lat;
      logic [31:0] rd;
      nb = nbytes(sz);
      idx = 0; bad = 0; lat = -1; rd = 'x;
      req_valid = 1; req_write = wr; req_size = sz; req_addr = a; req_wdata = d;
      chk({tag, ".ready_at_req"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 0; req_addr = ~a; req_wdata = ~d; req_write = ~wr;
      for (int k = 1; k <= 60; k++) begin
         if (k > 1) @(negedge clk);
         if (mem_we) begin
            if (idx >= 4 || mem_addr !== a + 16'(idx) || mem_wdata !== d[8 * (idx % 4) +: 8]) bad++;
            idx++;
         end
         if (resp_valid) begin
            lat = k;
            rd = resp_rdata;
            break;
         end
      end
      chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".we_cycles"}, 32'(idx), 32'(wr ? nb : 0));
      if (wr) chk({tag, ".wr_bytes_bad"}, 32'(bad), 32'd0);
      else chk({tag, ".rdata"}, rd, exp_rd);
      @(negedge clk);
      chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
      if (wr) for (int j = 0; j < nb; j++) ref_mem[a + 16'(j)] = d[8 * j +: 8];
   endtask

   initial begin
      for (int j = 0; j < 65536; j++) begin
         mem[j] = 0;
         ref_mem[j] = 0;
      end
      vecs[0] = '{1, 2'd2, 16'hfff8, 32'hDEADBEEF, 32'h0, 5};
      vecs[1] = '{0, 2'd2, 16'hfff8, 32'h0, 32'hDEADBEEF, 9};
      vecs[2] = '{1, 2'd0, 16'h8010, 32'h0000005A, 32'h0, 2};
      vecs[3] = '{1, 2'd0, 16'h8011, 32'h000000C3, 32'h0, 2};
      vecs[4] = '{0, 2'd1, 16'h8010, 32'h0, 32'h0000C35A, 5};
      vecs[5] = '{1, 2'd2, 16'hfffe, 32'h11223344, 32'h0, 5};
      vecs[6] = '{0, 2'd2, 16'h0000, 32'h0, 32'h00001122, 9};
      vecs[7] = '{0, 2'd3, 16'hfffe, 32'h0, 32'h11223344, 9};
      vecs[8] = '{0, 2'd0, 16'hffff, 32'h0, 32'h00000033, 3};
      reset = 1; req_valid = 0; req_write = 0; req_size = 0; req_addr = 0; req_wdata = 0;
      #1;
      chk("rst.req_ready", 32'(req_ready), 32'd0);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.mem_we", 32'(mem_we), 32'd0);
      chk("rst.mem_addr", 32'(mem_addr), 32'd0);
      chk("rst.resp_rdata", resp_rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      #1;
      chk("rst.ready_release", 32'(req_ready), 32'd1);
      @(negedge clk);
      for (int v = 0; v < 9; v++) begin
         xfer($sformatf("vec%0d", v), vecs[v].wr, vecs[v].sz, vecs[v].a, vecs[v].d, vecs[v].exp_rd, vecs[v].exp_lat);
         if (v == 0) chk("io_outputs", {mem[16'hfffb], mem[16'hfffa], mem[16'hfff9], mem[16'hfff8]}, 32'hDEADBEEF);
         if (v == 5) chk("wrap_mem", {mem[16'h0001], mem[16'h0000], mem[16'hffff], mem[16'hfffe]}, 32'h11223344);
      end
      // request held through a transfer with changing address is only taken once idle again
      req_valid = 1; req_write = 1; req_size = 2'd0; req_addr = 16'h2000; req_wdata = 32'h77;
      @(posedge clk);
      @(negedge clk);
      req_addr = 16'h3000; req_wdata = 32'h99;
      chk("hold.c1_addr", 32'(mem_addr), 32'h2000);
      chk("hold.c1_data", 32'(mem_wdata), 32'h77);
      @(negedge clk);
      chk("hold.c2_resp", 32'(resp_valid), 32'd1);
      chk("hold.c2_ready", 32'(req_ready), 32'd0);
      chk("hold.c2_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      chk("hold.c3_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      chk("hold.c4_we", 32'(mem_we), 32'd1);
      chk("hold.c4_addr", 32'(mem_addr), 32'h3000);
      chk("hold.c4_data", 32'(mem_wdata), 32'h99);
      begin
         bit seen = 0;
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = resp_valid;
         end
         chk("hold.second_resp", 32'(seen), 32'd1);
      end
      @(negedge clk);
      ref_mem[16'h2000] = 8'h77;
      ref_mem[16'h3000] = 8'h99;
      xfer("hold.rd2000", 0, 2'd0, 16'h2000, 0, 32'h77, 1 * RD_LAT + 1);
      // reset in cycle 2 of a word write: first byte lands, the rest never do
      req_valid = 1; req_write = 1; req_size = 2'd2; req_addr = 16'h4000; req_wdata = 32'hAABBCCDD;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      chk("mid.c1_we", 32'(mem_we), 32'd1);
      @(posedge clk);
      #2 reset = 1;
      #1;
      chk("mid.we_forced", 32'(mem_we), 32'd0);
      chk("mid.ready_low", 32'(req_ready), 32'd0);
      ref_mem[16'h4000] = 8'hDD;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      #1;
      chk("mid.ready_release", 32'(req_ready), 32'd1);
      begin
         bit seen = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen |= resp_valid;
         end
         chk("mid.no_resp", 32'(seen), 32'd0);
      end
      xfer("mid.rd4000", 0, 2'd0, 16'h4000, 0, ref_read(16'h4000, 1), RD_LAT + 1);
      xfer("mid.rd4001", 0, 2'd0, 16'h4001, 0, ref_read(16'h4001, 1), RD_LAT + 1);
      // randomized traffic, addresses biased toward the wrap point and a small window
      for (int t = 0; t < 60; t++) begin
         bit wr = 1'($urandom);
         logic [1:0] sz = 2'($urandom);
         logic [15:0] a = ($urandom_range(0, 2) == 0) ? 16'(16'hfffc + $urandom_range(0, 7)) : 16'(16'h5000 + $urandom_range(0, 15));
         logic [31:0] d = $urandom;
         int nb = nbytes(sz);
         xfer($sformatf("rnd%0d", t), wr, sz, a, d, wr ? 32'h0 : ref_read(a, nb), wr ? nb + 1 : nb * RD_LAT + 1);
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Bus initiator for the byte-wide memory/IO block: accepts one 1-, 2- or 4-byte transfer request from the CPU datapath and sequences it into single-byte accesses on the 16-bit address / 8-bit data memory interface.
- Byte order is little-endian.
- Memory-mapped IO at 16'hfff8-16'hffff gets no special treatment; it is accessed like RAM.

Parameters:
- RD_LAT, 2: cycles mem_addr is held per read byte before mem_rdata is sampled; legal range 1-4.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block idle, request accepted on this edge if req_valid.
- req_write  input  1  1 = write, 0 = read.
- req_size  input  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = treated as 4 bytes.
- req_addr  input  16  address of byte 0.
- req_wdata  input  32  write data; byte i is req_wdata[8i+7:8i].
- resp_valid  output  1  one-cycle pulse: transfer complete.
- resp_rdata  output  32  read result; valid while resp_valid, held until the next read completes.
- mem_addr  output  16  memory address.
- mem_wdata  output  8  memory write data.
- mem_we  output  1  memory write enable.
- mem_rdata  input  8  memory read data.

Behaviour:
- Reset values (async, immediate):
  - req_ready = 0 while reset is high; 1 in the first cycle after release.
  - resp_valid = 0; resp_rdata = 0; mem_addr = 0; mem_wdata = 0; mem_we = 0.
  - State IDLE; byte counter and wait counter = 0.
- States: IDLE, WR, RD, DONE. req_ready = 1 only in IDLE.
- IDLE:
  - On posedge with req_valid = 1, latch write, N (1/2/4), addr and wdata.
  - Go to WR or RD with byte index i = 0.
  - req_valid = 0: stay in IDLE; mem_addr holds its last value; mem_we = 0.
- WR:
  - Each cycle drive mem_addr = addr + i, mem_wdata = byte i, mem_we = 1. Exactly one cycle per byte.
  - After byte N-1, go to DONE; mem_we drops to 0 in DONE.
- RD:
  - Drive mem_addr = addr + i with mem_we = 0 for RD_LAT cycles.
  - On the edge ending the RD_LAT-th cycle, capture mem_rdata into resp_rdata byte lane i.
  - Then i+1, or DONE after byte N-1.
  - resp_rdata lanes >= N are cleared to 0 when a read is accepted.
- DONE: resp_valid = 1 for exactly one cycle, then IDLE.
- Latency (request accepted at edge 0, cycle k = cycle after edge k-1):
  - Write: mem_we high in cycles 1..N; resp_valid in cycle N+1; req_ready in cycle N+2.
  - Read: resp_valid in cycle N*RD_LAT+1; req_ready in cycle N*RD_LAT+2.
- Address arithmetic: addr + i is a 16-bit sum that wraps modulo 2^16, e.g. a 4-byte access at 16'hfffe touches fffe, ffff, 0000, 0001.
- req_valid while not IDLE: ignored; the request is not latched and there is no queueing. The requester must hold req_valid until it sees req_ready.
- Request inputs changing mid-transfer: no effect; all values were latched at accept.
- Reset mid-transfer:
  - Transfer abandoned and mem_we forced to 0 immediately.
  - No resp_valid is generated.
  - Partially written bytes remain in memory.
- No unaligned restriction: any address is legal for any size.

Decomposition:
- Shared package mem_master_pkg holds:
  - Size encodings SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2.
  - State encoding (IDLE, WR, RD, DONE).
  - IO window constants IO_OUT_BASE = 16'hfff8 and IO_IN_BASE = 16'hfffc, for benches.
- No sub-module: a single FSM with byte and wait counters is the natural size.

Test Plan:
- Word write 32'hDEADBEEF to 16'hfff8 with the memory block attached -> mem_we high cycles 1-4 at fff8..fffb with data EF, BE, AD, DE; resp_valid in cycle 5; io_outputs = 32'hDEADBEEF.
- Word read of 16'hfff8 after that write (RD_LAT = 2) -> resp_valid in cycle 9, resp_rdata = 32'hDEADBEEF; mem_we stays 0 throughout.
- Byte write 8'h5A to 16'h8010, then half read at 16'h8010 after a byte write 8'hC3 to 16'h8011 -> resp_rdata = 32'h0000C35A.
- Word write 32'h11223344 at 16'hfffe -> byte writes at fffe = 44, ffff = 33, 0000 = 22, 0001 = 11; addresses wrap to 0000.
- req_valid held during an active transfer with different addr -> ignored; second request accepted only in the cycle after req_ready returns to 1.
- reset asserted in cycle 2 of a word write -> mem_we = 0 and req_ready = 0 immediately; no resp_valid; req_ready = 1 the first cycle after release; a fresh byte read then completes normally.
